// File: rtl/pwm_ctrl_pkg.sv
// Shared types and widths for the PWM frame controller.
package pwm_ctrl_pkg;
  localparam int SYM_W    = 8;
  localparam int SAMPLE_W = 16;

  typedef enum logic [1:0] {IDLE, ARM, RUN, FLUSH} state_t;

  // |s| one bit wider than the sample so that the most negative value maps to +2^(W-1)
  function automatic logic [SAMPLE_W:0] sample_mag(input logic signed [SAMPLE_W-1:0] s);
    logic [SAMPLE_W:0] ext;
    ext = {s[SAMPLE_W-1], s};
    return s[SAMPLE_W-1] ? (~ext + 1'b1) : ext;
  endfunction
endpackage

// File: rtl/pwm_frame_ctrl_if.sv
// Valid/ready symbol stream leaving the frame controller.
interface pwm_frame_ctrl_if;
  import pwm_ctrl_pkg::*;
  logic signed [SYM_W-1:0] out_symbol;
  logic                    out_last;
  logic                    out_valid;
  logic                    out_ready;

  modport master (output out_symbol, out_last, out_valid, input out_ready);
  modport slave  (input out_symbol, out_last, out_valid, output out_ready);
endinterface

// File: rtl/pwm_sym_fifo.sv
// Symbol FIFO; pointers carry one extra bit to tell full from empty. DEPTH >= 2, power of two.
module pwm_sym_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             empty,
  output logic             full
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  // zero when empty so the stream reads 0 after reset without clearing storage
  assign rdata   = empty ? '0 : mem[rd_ptr[AW-1:0]];

  // pointer update, wrapping naturally modulo 2*DEPTH
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // storage write; contents need no reset
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end
endmodule

// File: rtl/pwm_frame_ctrl.sv
// Frame controller: squelch-armed capture of decoded symbols into a stream FIFO.
module pwm_frame_ctrl
  import pwm_ctrl_pkg::*;
#(
  parameter int SYMS_PER_FRAME  = 4,
  parameter int SILENCE_TIMEOUT = 1024,
  parameter int FIFO_DEPTH      = 8
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic signed [SAMPLE_W-1:0] data_in,
  input  logic signed [SAMPLE_W-1:0] ref_in,
  input  logic                       sym_valid,
  input  logic signed [SYM_W-1:0]    sym_in,
  output logic                       enable_counter,
  output logic                       dec_clear,
  output logic                       overflow,
  output logic                       frame_abort,
  pwm_frame_ctrl_if.master           sym_out
);
  state_t          state, state_nx;
  logic [SAMPLE_W:0] mag;
  logic            active, act_prev;
  logic [15:0]     sil_cnt;
  logic [7:0]      sym_cnt;
  logic            fifo_empty, fifo_full;
  logic            pop, push, take, drop, is_last, abort_now;
  logic [SYM_W:0]  fifo_rdata;

  assign mag       = sample_mag(data_in);
  // 18-bit signed compare: magnitude is never negative, a non-positive ref never arms
  assign active    = $signed({1'b0, mag}) > $signed({{2{ref_in[SAMPLE_W-1]}}, ref_in});
  assign pop       = !fifo_empty && sym_out.out_ready;
  assign abort_now = (state == RUN) && !active && (sil_cnt == 16'(SILENCE_TIMEOUT - 1));
  assign take      = (state == RUN) && sym_valid && !abort_now;
  assign is_last   = (sym_cnt == 8'(SYMS_PER_FRAME - 1));
  assign push      = take && (!fifo_full || pop);
  assign drop      = take && fifo_full && !pop;

  // state register
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // next state and state-decoded decoder controls
  always_comb begin
    state_nx       = state;
    enable_counter = 1'b0;
    dec_clear      = 1'b0;
    case (state)
      IDLE:  if (active && act_prev) state_nx = ARM;
      ARM: begin
        dec_clear = 1'b1;
        state_nx  = RUN;
      end
      RUN: begin
        enable_counter = 1'b1;
        if (abort_now)              state_nx = IDLE;
        else if (take && is_last)   state_nx = FLUSH;
      end
      FLUSH: if (fifo_empty) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // arming history plus silence/symbol counters, all held at zero outside RUN
  always_ff @(posedge clock) begin
    if (reset) begin
      act_prev <= 1'b0;
      sil_cnt  <= '0;
      sym_cnt  <= '0;
    end else begin
      act_prev <= (state == IDLE) && active;
      if (state != RUN || abort_now) begin
        sil_cnt <= '0;
        sym_cnt <= '0;
      end else begin
        sil_cnt <= active ? '0 : sil_cnt + 16'd1;
        // dropped symbols still count so the frame length is preserved
        if (take) sym_cnt <= is_last ? '0 : sym_cnt + 8'd1;
      end
    end
  end

  // one-cycle event pulses
  always_ff @(posedge clock) begin
    if (reset) begin
      overflow    <= 1'b0;
      frame_abort <= 1'b0;
    end else begin
      overflow    <= drop;
      frame_abort <= abort_now;
    end
  end

  pwm_sym_fifo #(.WIDTH(SYM_W + 1), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .wdata ({sym_in, is_last}),
    .rdata (fifo_rdata),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  assign sym_out.out_valid  = !fifo_empty;
  assign sym_out.out_symbol = fifo_rdata[SYM_W:1];
  assign sym_out.out_last   = fifo_rdata[0];
endmodule

// File: tb/tb_pwm_frame_ctrl.sv
// Bench: two controllers (4- and 16-symbol frames) against a queue-based reference model.
module tb_pwm_frame_ctrl;
  import pwm_ctrl_pkg::*;

  localparam int TMO   = 1024;
  localparam int DEPTH = 8;

  logic clock;
  logic reset;
  logic signed [15:0] din_a, din_b, ref_in;
  logic sym_valid;
  logic signed [7:0] sym_in;
  logic out_ready;
  logic en4, dc4, ov4, fa4, en16, dc16, ov16, fa16;

  int n_cmp = 0;
  int n_bad = 0;
  bit started = 0;

  pwm_frame_ctrl_if s4 ();
  pwm_frame_ctrl_if s16 ();
  assign s4.out_ready  = out_ready;
  assign s16.out_ready = out_ready;

  pwm_frame_ctrl #(.SYMS_PER_FRAME(4), .SILENCE_TIMEOUT(TMO), .FIFO_DEPTH(DEPTH)) dut4 (
    .clock(clock), .reset(reset), .data_in(din_a), .ref_in(ref_in),
    .sym_valid(sym_valid), .sym_in(sym_in), .enable_counter(en4), .dec_clear(dc4),
    .overflow(ov4), .frame_abort(fa4), .sym_out(s4));

  pwm_frame_ctrl #(.SYMS_PER_FRAME(16), .SILENCE_TIMEOUT(TMO), .FIFO_DEPTH(DEPTH)) dut16 (
    .clock(clock), .reset(reset), .data_in(din_b), .ref_in(ref_in),
    .sym_valid(sym_valid), .sym_in(sym_in), .enable_counter(en16), .dec_clear(dc16),
    .overflow(ov16), .frame_abort(fa16), .sym_out(s16));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // reference model state, index 0 = 4-symbol frames, 1 = 16-symbol frames
  state_t     m_st [2];
  bit         m_pa [2];
  int         m_sil[2], m_cnt[2], m_n[2];
  logic [8:0] m_q  [2][DEPTH];
  bit         m_ovf[2], m_abt[2];

  task automatic cmp(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic mstep(input int i, input int syms, input int din);
    int mag; bit act, pop, push, last; logic [8:0] ent; state_t nst;
    mag = (din < 0) ? -din : din;
    act = mag > int'(ref_in);
    if (reset) begin
      m_st[i] = IDLE; m_pa[i] = 0; m_sil[i] = 0; m_cnt[i] = 0; m_n[i] = 0;
      m_ovf[i] = 0; m_abt[i] = 0;
      return;
    end
    pop = (m_n[i] > 0) && out_ready;
    push = 0; ent = '0; last = 0; nst = m_st[i];
    m_ovf[i] = 0; m_abt[i] = 0;
    if (m_st[i] != RUN) begin m_sil[i] = 0; m_cnt[i] = 0; end
    case (m_st[i])
      IDLE:  if (act && m_pa[i]) nst = ARM;
      ARM:   nst = RUN;
      RUN: begin
        if (!act && m_sil[i] == TMO - 1) begin
          m_abt[i] = 1; nst = IDLE; m_sil[i] = 0; m_cnt[i] = 0;
        end else begin
          m_sil[i] = act ? 0 : m_sil[i] + 1;
          if (sym_valid) begin
            last = (m_cnt[i] == syms - 1);
            if (m_n[i] < DEPTH || pop) begin push = 1; ent = {sym_in, last}; end
            else m_ovf[i] = 1;
            if (last) begin m_cnt[i] = 0; nst = FLUSH; end
            else m_cnt[i]++;
          end
        end
      end
      FLUSH: if (m_n[i] == 0) nst = IDLE;
      default: nst = IDLE;
    endcase
    m_pa[i] = (m_st[i] == IDLE) && act;
    if (pop) begin
      for (int k = 0; k < DEPTH - 1; k++) m_q[i][k] = m_q[i][k+1];
      m_n[i]--;
    end
    if (push) begin m_q[i][m_n[i]] = ent; m_n[i]++; end
    m_st[i] = nst;
  endtask

  // advance the model on the same edge the DUTs sample
  always @(posedge clock) begin
    mstep(0, 4, int'(din_a));
    mstep(1, 16, int'(din_b));
    if (reset) started = 1;
  end

  task automatic check_inst(input int i, input string tag, input logic en, dc, ov, fa,
                            input logic v, l, input logic signed [7:0] sy, input state_t st);
    logic signed [7:0] es;
    logic el;
    es = (m_n[i] > 0) ? $signed(m_q[i][0][8:1]) : 8'sd0;
    el = (m_n[i] > 0) ? m_q[i][0][0] : 1'b0;
    cmp({tag, ".out_valid"},      int'(v),  int'(m_n[i] > 0));
    cmp({tag, ".out_symbol"},     int'(sy), int'(es));
    cmp({tag, ".out_last"},       int'(l),  int'(el));
    cmp({tag, ".enable_counter"}, int'(en), int'(m_st[i] == RUN));
    cmp({tag, ".dec_clear"},      int'(dc), int'(m_st[i] == ARM));
    cmp({tag, ".overflow"},       int'(ov), int'(m_ovf[i]));
    cmp({tag, ".frame_abort"},    int'(fa), int'(m_abt[i]));
    cmp({tag, ".state"},          int'(st), int'(m_st[i]));
  endtask

  // every-cycle comparison, away from the sampling edge
  always @(negedge clock) begin
    if (started) begin
      check_inst(0, "d4",  en4,  dc4,  ov4,  fa4,  s4.out_valid,  s4.out_last,  s4.out_symbol,  dut4.state);
      check_inst(1, "d16", en16, dc16, ov16, fa16, s16.out_valid, s16.out_last, s16.out_symbol, dut16.state);
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  int arm_seq[5] = '{0, -8, -55, -125, -190};
  int syms_b[4]  = '{7, -3, 2, 5};
  int ov_seen;
  int k_ab;

  initial begin
    reset = 1; din_a = 0; din_b = 0; ref_in = 16'sd65;
    sym_valid = 0; sym_in = 0; out_ready = 1;
    repeat (3) tick();
    cmp("reset out_valid", int'(s4.out_valid), 0);
    cmp("reset enable", int'(en4), 0);
    cmp("reset idle", int'(dut4.state == IDLE), 1);

    // squelch arming: only -125 and -190 exceed 65
    reset = 0;
    for (int k = 0; k < 5; k++) begin
      din_a = 16'(arm_seq[k]); din_b = 16'(arm_seq[k]);
      tick();
    end
    cmp("arm dec_clear", int'(dc4), 1);
    cmp("arm enable", int'(en4), 0);
    din_a = 16'sd200; din_b = 16'sd200;
    tick();
    cmp("run dec_clear", int'(dc4), 0);
    cmp("run enable", int'(en4), 1);

    // four-symbol frame, drained immediately
    for (int k = 0; k < 4; k++) begin
      sym_valid = 1; sym_in = 8'(syms_b[k]);
      if (k == 3) din_a = 0;
      tick();
      sym_valid = 0;
      if (k == 0) begin
        cmp("latency out_valid", int'(s4.out_valid), 1);
        cmp("latency out_symbol", int'(s4.out_symbol), 7);
        cmp("first not last", int'(s4.out_last), 0);
      end
      if (k < 3) tick();
    end
    cmp("last symbol", int'(s4.out_symbol), 5);
    cmp("last flag", int'(s4.out_last), 1);
    cmp("flush entered", int'(dut4.state == FLUSH), 1);
    tick();
    cmp("flush drained", int'(s4.out_valid), 0);
    cmp("flush hold", int'(dut4.state == FLUSH), 1);
    tick();
    cmp("flush to idle", int'(dut4.state == IDLE), 1);

    // backpressure: 9 strobes into an 8-deep FIFO, then push+pop on full
    out_ready = 0; ov_seen = 0;
    for (int k = 0; k < 9; k++) begin
      sym_valid = 1; sym_in = 8'(10 + k);
      tick();
      ov_seen += int'(ov16);
    end
    sym_in = 8'sd19; out_ready = 1;
    tick();
    ov_seen += int'(ov16);
    sym_valid = 0; out_ready = 0;
    tick();
    ov_seen += int'(ov16);
    cmp("overflow pulses", ov_seen, 1);
    cmp("held out_symbol", int'(s16.out_symbol), 11);
    cmp("held out_valid", int'(s16.out_valid), 1);
    cmp("idle ignores sym_valid", int'(s4.out_valid), 0);

    // silence abort keeps queued symbols
    din_b = 0; k_ab = 0;
    for (int k = 1; k <= 1100; k++) begin
      tick();
      if (fa16) begin k_ab = k; break; end
    end
    cmp("abort cycle", k_ab, 1024);
    cmp("abort idle", int'(dut16.state == IDLE), 1);
    cmp("abort keeps fifo", int'(s16.out_valid), 1);
    cmp("abort no last", int'(s16.out_last), 0);
    out_ready = 1;
    repeat (8) tick();
    cmp("abort drained", int'(s16.out_valid), 0);

    // full-scale magnitude: 32767 is not > 32767, -32768 is
    ref_in = 16'sd32767; din_a = 16'sd32767;
    tick();
    cmp("max not active", int'(dc4), 0);
    din_a = -16'sd32768;
    tick();
    cmp("one active sample", int'(dc4), 0);
    tick();
    cmp("min arms", int'(dc4), 1);
    tick();
    cmp("min run", int'(en4), 1);

    // reset mid-frame with three queued symbols
    out_ready = 0;
    for (int k = 1; k <= 3; k++) begin
      sym_valid = 1; sym_in = 8'(k);
      tick();
    end
    sym_valid = 0;
    cmp("queued before reset", int'(s4.out_valid), 1);
    reset = 1;
    tick();
    cmp("reset flush out_valid", int'(s4.out_valid), 0);
    cmp("reset enable off", int'(en4), 0);
    cmp("reset state idle", int'(dut4.state == IDLE), 1);
    reset = 0;
    tick();
    cmp("post reset empty", int'(s4.out_valid), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
